uart_rx_byte: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_byte.sv | 146 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-timing helper
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // Clock cycles per line bit (integer divide), shared by RX and TX
  function automatic int ticks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the idle-high serial line
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Resets to 1 so a reset never looks like a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with byte strobe and framing-error pulse
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 1000000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int BIT_TICKS  = ticks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS);
  localparam int IDX_W      = 4;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Too few ticks per bit leaves no room for a mid-bit sample point
  if (BIT_TICKS < 4) begin : g_bad_ticks
    $error("uart_rx_byte: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx_byte: DATA_BITS must be in 1..8");
  end

  uart_rx_state_e       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  // State, counters and output registers; reset aborts any frame in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Frame sequencing: half-bit to the start centre, then whole bits to each data/stop centre
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // LSB arrives first, so each new bit enters at the top and walks down
          shift_d = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

  localparam int BT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  uart_rx_byte #(
    .CLOCK_FREQUENCY (16),
    .BAUD_RATE       (1),
    .DATA_BITS       (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         fe;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t evq[$];
  bit  overlap_seen = 1'b0;

  // Record every strobe with the cycle it was seen
  always @(negedge clock) begin
    if (data_valid && framing_error) overlap_seen <= 1'b1;
    if (data_valid)    evq.push_back('{fe: 1'b0, data: data_out, cyc: cyc});
    if (framing_error) evq.push_back('{fe: 1'b1, data: data_out, cyc: cyc});
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rd_idx   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int t0);
    t0 = cyc;
    hold(1'b0, BT);
    for (int i = 0; i < 8; i++) hold(d[i], BT);
    hold(stop_bit, BT);
  endtask

  task automatic expect_none(input string nm);
    check({nm, "_no_strobe"}, evq.size() - rd_idx, 0);
    rd_idx = evq.size();
  endtask

  // Strobe due about 2 + HALF + 9*BIT = 154 cycles after the start edge
  task automatic expect_frame(input string nm, input int t0, input bit efe, input logic [7:0] edata);
    int  n;
    ev_t e;
    n = evq.size() - rd_idx;
    check({nm, "_count"}, n, 1);
    if (n >= 1) begin
      e = evq[rd_idx];
      check({nm, "_ferr"}, e.fe, efe);
      check({nm, "_data"}, e.data, edata);
      check({nm, "_latency_ok"}, ((e.cyc - t0) >= 151 && (e.cyc - t0) <= 157), 1);
    end
    rd_idx = evq.size();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap;
    bit         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] model_last;

  // Reference: a good stop delivers the byte, a bad stop flags and keeps the last good byte
  task automatic add_vec(input logic [7:0] d, input logic stop_ok, input int gap);
    vec_t v;
    v.data     = d;
    v.stop_ok  = stop_ok;
    v.gap      = stop_ok ? gap : ((gap < BT) ? BT : gap);
    v.exp_fe   = !stop_ok;
    v.exp_data = stop_ok ? d : model_last;
    if (stop_ok) model_last = d;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_data_out", data_out, 8'h00);
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_framing_error", framing_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    hold(1'b1, 4);

    model_last = 8'h00;
    add_vec(8'h55, 1'b1, 16);
    add_vec(8'hA3, 1'b1, 0);
    add_vec(8'h0F, 1'b1, 16);
    add_vec(8'hFF, 1'b1, 0);
    add_vec(8'h00, 1'b1, 20);
    for (int i = 0; i < 12; i++) begin
      add_vec(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 20));
    end

    foreach (tbl[i]) begin
      send_frame(tbl[i].data, tbl[i].stop_ok, t0);
      check($sformatf("vec%0d_busy_end", i), busy, !tbl[i].stop_ok);
      hold(1'b1, tbl[i].gap);
      expect_frame($sformatf("vec%0d", i), t0, tbl[i].exp_fe, tbl[i].exp_data);
      if (!tbl[i].stop_ok) check($sformatf("vec%0d_busy_idle", i), busy, 1'b0);
    end

    hold(1'b1, 20);
    hold(1'b0, 5);
    check("glitch_busy_during", busy, 1'b1);
    hold(1'b1, 12);
    check("glitch_busy_after", busy, 1'b0);
    expect_none("glitch");

    send_frame(8'h3C, 1'b0, t0);
    hold(1'b0, 100);
    check("break_busy_held", busy, 1'b1);
    expect_frame("break_frame", t0, 1'b1, model_last);
    check("break_data_kept", data_out, model_last);
    hold(1'b1, 20);
    check("break_busy_released", busy, 1'b0);
    expect_none("break_release");
    send_frame(8'h5A, 1'b1, t0);
    hold(1'b1, 8);
    expect_frame("after_break", t0, 1'b0, 8'h5A);
    model_last = 8'h5A;

    hold(1'b0, BT);
    for (int i = 0; i < 4; i++) hold(i[0], BT);
    hold(1'b1, BT / 2);
    reset = 1'b1;
    #1;
    check("midreset_data_out", data_out, 8'h00);
    check("midreset_busy", busy, 1'b0);
    check("midreset_valid", data_valid, 1'b0);
    @(negedge clock);
    hold(1'b1, 3);
    reset = 1'b0;
    model_last = 8'h00;
    hold(1'b1, 2 * BT);
    expect_none("midreset");
    check("midreset_busy_after", busy, 1'b0);
    send_frame(8'h81, 1'b1, t0);
    hold(1'b1, 8);
    expect_frame("post_reset", t0, 1'b0, 8'h81);

    check("strobe_exclusive", overlap_seen, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
